// File: rtl/flip_flop_fifo_status.sv
`default_nettype none
// ============================================================================
//  Module   : flip_flop_fifo_status
//  Purpose  : Register-based FIFO of arbitrary (non-power-of-two) depth with
//             occupancy count, programmable almost-full / almost-empty flags,
//             protected push/pop, sticky overflow/underflow flags and a
//             synchronous clear.
//  Ports    : clk, rst (async, active-high)  - clock and reset
//             clear                          - synchronous flush of pointers,
//                                              count and error flags
//             push / write_data              - write request and data
//             pop / read_data                - read request, show-ahead head
//             empty, full, almost_full,
//             almost_empty, count            - status from registered count
//             overflow, underflow            - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module flip_flop_fifo_status #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10,
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_th    = CW'(AF_TH);
    localparam logic [CW-1:0] c_ae_th    = CW'(AE_TH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Status is derived solely from the registered count, so no request
    // input ever reaches a status output combinationally.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // A push into a full FIFO is still accepted when a pop frees the slot
    // in the same cycle; the write lands where the head is leaving.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past
    // the last entry.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            // Requests in a clear cycle are dropped and raise no flags.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            if (push & ~w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are qualified by count alone.
    always_ff @(posedge clk) begin
        if (w_push_ok & ~clear) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    assign read_data    = r_mem[r_rd_ptr];
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= c_af_th);
    assign almost_empty = (r_count <= c_ae_th);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_flip_flop_fifo_status.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flip_flop_fifo_status
//  Purpose  : Self-checking bench for flip_flop_fifo_status. A queue-based
//             reference model tracks contents and sticky flags; directed
//             scenarios are followed by randomized push/pop/clear traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flip_flop_fifo_status;

    localparam int WIDTH = 8;
    localparam int DEPTH = 10;
    localparam int AF_TH = 8;
    localparam int AE_TH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    flip_flop_fifo_status #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AF_TH (AF_TH),
        .AE_TH (AE_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .write_data   (write_data),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue plus sticky flags.
    logic [WIDTH-1:0] model_q[$];
    bit               model_ov;
    bit               model_uf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        int n;
        n = model_q.size();
        check({where, ".count"},        32'(count),        32'(n));
        check({where, ".empty"},        32'(empty),        32'(n == 0));
        check({where, ".full"},         32'(full),         32'(n == DEPTH));
        check({where, ".almost_full"},  32'(almost_full),  32'(n >= AF_TH));
        check({where, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE_TH));
        check({where, ".overflow"},     32'(overflow),     32'(model_ov));
        check({where, ".underflow"},    32'(underflow),    32'(model_uf));
        if (n > 0) begin
            check({where, ".read_data"}, 32'(read_data), 32'(model_q[0]));
        end
        check({where, ".wr_ptr_range"}, 32'(dut.r_wr_ptr < DEPTH), 32'd1);
        check({where, ".rd_ptr_range"}, 32'(dut.r_rd_ptr < DEPTH), 32'd1);
    endtask

    task automatic model_update(input bit p, input bit po, input bit c, input logic [WIDTH-1:0] d);
        bit pop_ok;
        bit push_ok;
        if (c) begin
            model_q.delete();
            model_ov = 1'b0;
            model_uf = 1'b0;
        end else begin
            pop_ok  = po && (model_q.size() > 0);
            push_ok = p && ((model_q.size() < DEPTH) || pop_ok);
            if (p && !push_ok)             model_ov = 1'b1;
            if (po && model_q.size() == 0) model_uf = 1'b1;
            if (pop_ok)                    void'(model_q.pop_front());
            if (push_ok)                   model_q.push_back(d);
        end
    endtask

    // One clock cycle: apply inputs, check the current outputs (which must
    // not depend on these inputs), clock, advance the model.
    task automatic step(input string where, input bit p, input bit po, input bit c,
                        input logic [WIDTH-1:0] d);
        push       = p;
        pop        = po;
        clear      = c;
        write_data = d;
        #1;
        check_outputs(where);
        @(posedge clk);
        model_update(p, po, c, d);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        write_data = '0;
        model_ov   = 1'b0;
        model_uf   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill with 0x01..0x0A, then drain in order
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
        check_outputs("filled");
        for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
        check_outputs("drained");

        // Overflow, then simultaneous push+pop while full
        for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, 1'b0, 1'b0, 8'(i));
        step("push_full", 1'b1, 1'b0, 1'b0, 8'hFF);
        check_outputs("after_ovf");
        step("pushpop_full", 1'b1, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, 1'b0, 8'h00);
        check_outputs("drained2");
        step("clr1", 1'b0, 1'b0, 1'b1, 8'h00);

        // Pointer wrap with count held at 3
        for (int i = 0; i < 3; i++) step("pre_wrap", 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 3; i < 28; i++) step("wrap", 1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
        check_outputs("after_wrap");
        step("clr2", 1'b0, 1'b0, 1'b1, 8'h00);

        // Empty with push+pop, then clear together with push
        step("pushpop_empty", 1'b1, 1'b1, 1'b0, 8'h55);
        check_outputs("after_udf");
        step("clear_push", 1'b1, 1'b0, 1'b1, 8'h66);
        check_outputs("after_clear");

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        push = 1'b0;
        #3;
        rst = 1'b1;
        model_q.delete();
        model_ov = 1'b0;
        model_uf = 1'b0;
        #1;
        check_outputs("async_rst");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, 1'b0, 1'b0, 8'h77);
        check_outputs("post_rst_chk");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step("rand",
                 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 2),
                 8'($urandom));
        end
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flip_flop_fifo_status.md
# flip_flop_fifo_status

Parametrised flip-flop FIFO with occupancy count, programmable almost-full/almost-empty thresholds, protected push/pop, sticky overflow/underflow error flags and a synchronous clear. It is the next generation of the team's register-based FIFO for small, arbitrary-depth (non-power-of-two) buffers between pipeline stages, where producers and consumers need early back-pressure and error visibility.

## Interface
- WIDTH, 8: data word width in bits (>= 1).
- DEPTH, 10: number of entries (>= 2; any integer, power of two not required).
- AF_TH, DEPTH-2: almost_full threshold, legal range 1..DEPTH.
- AE_TH, 2: almost_empty threshold, legal range 0..DEPTH-1.
- CW (localparam) = $clog2(DEPTH+1); PW (localparam) = max(1, $clog2(DEPTH)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- clear  in  1  synchronous flush of pointers, count and error flags.
- push  in  1  write request.
- pop  in  1  read request.
- write_data  in  WIDTH  data written on an accepted push.
- read_data  out  WIDTH  current head entry (show-ahead).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

## Operation
- pop_ok = pop & ~empty.
- push_ok = push & (~full | pop_ok). A push while full is accepted only when a pop is accepted in the same cycle.
- Pointers wr_ptr and rd_ptr (PW bits) advance by 1 on push_ok and pop_ok respectively. They wrap from DEPTH-1 to 0 and never take values >= DEPTH.
- Storage: mem[wr_ptr] <= write_data on push_ok. Storage is not reset or cleared.
- count_next = count + push_ok - pop_ok, computed in CW bits. It never exceeds DEPTH and never goes below 0.
- Status outputs are combinational from the registered count only, never from push or pop.
- read_data = mem[rd_ptr]. Its value is don't-care while empty.
- overflow is set on push & ~push_ok. underflow is set on pop & empty. Both hold until clear or rst.
- clear has priority over push and pop in the same cycle. On clear: pointers = 0, count = 0, overflow = underflow = 0. The push and pop in that cycle are ignored and set no flags.
- Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
- Reset mid-operation: all of the above take effect immediately and asynchronously. Stored data is abandoned.

## Timing
- No fall-through path. A word pushed at edge N appears on read_data, with empty = 0, after edge N, so it is readable in cycle N+1.
- Pop semantics: sample read_data in the cycle pop is asserted. The next entry is presented after the edge.
- All status flags and count update one edge after the accepted event.
- Full with push and pop in the same cycle: both are accepted and count stays at DEPTH. The write lands in the slot being vacated. read_data shows the old head in that cycle and the next entry afterwards.
- Empty with push and pop in the same cycle: push is accepted, pop is rejected and underflow is set. count becomes 1.
- Error flags are set at the edge that follows the offending request.

## Test plan
- DEPTH=10, WIDTH=8, AF_TH=8, AE_TH=2:
  - Reset, then push 0x01..0x0A on consecutive cycles -> count steps 1..10; almost_empty drops when count=3; almost_full rises when count=8; full=1 after the 10th push.
  - Pop all 10 entries -> read_data is 0x01..0x0A in order; empty=1 after the 10th pop.
- Fill to full, then assert push with 0xFF alone -> overflow=1, count=10, contents unchanged. Next, push 0xAA with pop together -> read_data=0x01 in that cycle, count stays 10, and 0xAA is read out as the 10th word after nine further pops.
- Pointer wrap: run 25 cycles of push+pop together at count=3 with an incrementing pattern -> strict FIFO order, count stays 3, and neither pointer reaches 10.
- Pop while empty together with push of 0x55 -> underflow=1, count=1, read_data=0x55. Then assert clear together with push -> count=0, empty=1, underflow=0, and the push is ignored.
- Push 4 words, then assert rst asynchronously between edges -> empty=1, count=0 and flags=0 immediately, without waiting for a clock edge. Then push 0x77 -> read_data=0x77 after one edge.
